// File: rtl/sync_rw_mem.sv
// sync_rw_mem: single-port synchronous RAM, one-word writes, registered 1-cycle reads, sync single-cycle clear
module sync_rw_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_d,
  output logic [DATA_W-1:0] rd_d
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_d <= '0;
    end else if (r_w) begin
      mem[addr] <= wr_d;
    end else begin
      rd_d <= mem[addr];
    end
  end
endmodule

// File: tb/tb_sync_rw_mem.sv
// tb_sync_rw_mem: directed scoreboard bench for sync_rw_mem
module tb_sync_rw_mem;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r_w = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wr_d = '0;
  logic [7:0] rd_d;
  int         total = 0;
  int         passed = 0;
  logic [7:0] model [16];
  logic [7:0] last = '0;
  logic [7:0] q [$];

  sync_rw_mem dut (
    .clk (clk),
    .rst (rst),
    .r_w (r_w),
    .addr(addr),
    .wr_d(wr_d),
    .rd_d(rd_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic rs, input logic rw, input logic [3:0] a, input logic [7:0] d);
    string tag;
    @(negedge clk);
    rst = rs; r_w = rw; addr = a; wr_d = d;
    if (rs) begin
      foreach (model[i]) model[i] = '0;
      last = '0;
      tag = "reset";
    end else if (rw) begin
      model[a] = d;
      tag = $sformatf("write_hold@%0d", a);
    end else begin
      last = model[a];
      tag = $sformatf("read@%0d", a);
    end
    q.push_back(last);
    @(posedge clk);
    #1;
    chk(tag, rd_d, q.pop_front());
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 7, 0);
    cyc(0, 0, 15, 0);
    cyc(0, 1, 3, 8'hA5);
    cyc(0, 0, 3, 0);
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 15, 8'hEE);
    cyc(0, 0, 15, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 5, 8'h3C);
    cyc(0, 1, 5, 8'hC3);
    cyc(0, 0, 5, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 8'(~i));
    for (int i = 0; i < 16; i++) cyc(0, 0, 4'(i), 0);
    cyc(0, 1, 9, 8'h7F);
    cyc(0, 0, 2, 0);
    cyc(1, 1, 9, 8'h55);
    cyc(0, 0, 9, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 15, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
